// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter in front of the RAM command/response path. It keeps the RAM
// bound to one requester across an address/data command pair and steers read
// data back to whichever port issued the read.
module spi_ram_arbiter #(
  parameter int LOCK_TIMEOUT = 64,
  parameter int RD_TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] p0_cmd,
  input  logic       p0_valid,
  output logic       p0_ready,
  output logic [7:0] p0_rdata,
  output logic       p0_rvalid,
  input  logic [9:0] p1_cmd,
  input  logic       p1_valid,
  output logic       p1_ready,
  output logic [7:0] p1_rdata,
  output logic       p1_rvalid,
  output logic [9:0] ram_rx_data,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_tx_data,
  input  logic       ram_tx_valid,
  output logic       owner,
  output logic       lock_timeout,
  output logic       rd_timeout,
  output logic       stray_rd
);

  localparam int TMAX = (LOCK_TIMEOUT > RD_TIMEOUT) ? LOCK_TIMEOUT : RD_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] RD_LAST   = TW'(RD_TIMEOUT - 1);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {IDLE, LOCK, WAIT_RD} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [9:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      p0_rdata_q, p0_rdata_d;
  logic [7:0]      p1_rdata_q, p1_rdata_d;
  logic            p0_rvalid_q, p0_rvalid_d;
  logic            p1_rvalid_q, p1_rvalid_d;
  logic            lock_to_q, lock_to_d;
  logic            rd_to_q, rd_to_d;
  logic            stray_q, stray_d;

  logic            acc;
  logic            gnt;
  logic [9:0]      acc_cmd;

  // Grant: round-robin on a tie in IDLE, owner-only in LOCK, nobody while a read is outstanding.
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_valid && p1_valid) begin
          p0_ready = owner_q;
          p1_ready = !owner_q;
        end else begin
          p0_ready = p0_valid;
          p1_ready = p1_valid;
        end
      end
      LOCK: begin
        p0_ready = p0_valid && !owner_q;
        p1_ready = p1_valid && owner_q;
      end
      default: ;
    endcase
  end

  assign acc     = p0_ready || p1_ready;
  assign gnt     = p1_ready;
  assign acc_cmd = gnt ? p1_cmd : p0_cmd;

  // Next-state, lock/read timers, command forwarding and read-data steering.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    lock_to_d   = 1'b0;
    rd_to_d     = 1'b0;
    stray_d     = ram_tx_valid && (state_q != WAIT_RD);

    if (acc) begin
      rx_data_d  = acc_cmd;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (acc) begin
          owner_d = gnt;
          timer_d = '0;
          unique case (acc_cmd[9:8])
            OP_WR_ADDR, OP_RD_ADDR: state_d = LOCK;
            OP_WR_DATA:             state_d = IDLE;
            OP_RD_DATA:             state_d = WAIT_RD;
          endcase
        end
      end
      LOCK: begin
        if (acc) begin
          timer_d = '0;
          unique case (acc_cmd[9:8])
            OP_WR_ADDR, OP_RD_ADDR: state_d = LOCK;
            OP_WR_DATA:             state_d = IDLE;
            OP_RD_DATA:             state_d = WAIT_RD;
          endcase
        end else if (timer_q == LOCK_LAST) begin
          state_d   = IDLE;
          timer_d   = '0;
          lock_to_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          state_d = IDLE;
          timer_d = '0;
          if (owner_q) begin
            p1_rdata_d  = ram_tx_data;
            p1_rvalid_d = 1'b1;
          end else begin
            p0_rdata_d  = ram_tx_data;
            p0_rvalid_d = 1'b1;
          end
        end else if (timer_q == RD_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          rd_to_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State and output registers; owner resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      timer_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      lock_to_q   <= 1'b0;
      rd_to_q     <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      lock_to_q   <= lock_to_d;
      rd_to_q     <= rd_to_d;
      stray_q     <= stray_d;
    end
  end

  assign ram_rx_data  = rx_data_q;
  assign ram_rx_valid = rx_valid_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign p0_rvalid    = p0_rvalid_q;
  assign p1_rvalid    = p1_rvalid_q;
  assign owner        = owner_q;
  assign lock_timeout = lock_to_q;
  assign rd_timeout   = rd_to_q;
  assign stray_rd     = stray_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: per-port command queues drive the ports, a small
// RAM model answers reads, and observed traffic is compared with expectations.
module tb_spi_ram_arbiter;
  localparam int LOCK_TIMEOUT = 64;
  localparam int RD_TIMEOUT   = 8;
  localparam logic [10:0] GAP = 11'h400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] p0_cmd = '0, p1_cmd = '0;
  logic       p0_valid = 1'b0, p1_valid = 1'b0;
  logic       p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic [9:0] ram_rx_data;
  logic       ram_rx_valid;
  logic [7:0] ram_tx_data = '0;
  logic       ram_tx_valid = 1'b0;
  logic       owner, lock_timeout, rd_timeout, stray_rd;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_cmd(p0_cmd), .p0_valid(p0_valid), .p0_ready(p0_ready),
    .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_cmd(p1_cmd), .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .ram_rx_data(ram_rx_data), .ram_rx_valid(ram_rx_valid),
    .ram_tx_data(ram_tx_data), .ram_tx_valid(ram_tx_valid),
    .owner(owner), .lock_timeout(lock_timeout), .rd_timeout(rd_timeout),
    .stray_rd(stray_rd)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [10:0] p0_q[$], p1_q[$];          // bit 10 set = idle cycle on that port
  logic [9:0]  exp_rx[$], obs_rx[$];
  int          obs_rx_cyc[$];
  logic [8:0]  exp_rd[$], obs_rd[$];      // {port, data}
  bit          acc0, acc1, ram_pend, ram_auto;
  logic [7:0]  ram_byte;
  int          acc0_cyc, acc1_cyc, n_lto, n_rto, n_stray, lto_cyc, rto_cyc;
  logic [9:0]  e10, o10;
  logic [8:0]  e9, o9;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs_rx.delete(); obs_rx_cyc.delete(); obs_rd.delete();
    exp_rx.delete(); exp_rd.delete();
    n_lto = 0; n_rto = 0; n_stray = 0; lto_cyc = -1; rto_cyc = -1;
    acc0_cyc = -1; acc1_cyc = -1;
  endtask

  // One clock cycle: drive ports, sample before the rising edge, retire accepted entries.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (p0_q.size() > 0) begin p0_valid = !p0_q[0][10]; p0_cmd = p0_q[0][9:0]; end
    else p0_valid = 1'b0;
    if (p1_q.size() > 0) begin p1_valid = !p1_q[0][10]; p1_cmd = p1_q[0][9:0]; end
    else p1_valid = 1'b0;
    ram_tx_valid = ram_pend;
    ram_tx_data  = ram_byte;
    ram_pend     = 1'b0;
    #4;
    acc0 = p0_valid && p0_ready;
    acc1 = p1_valid && p1_ready;
    if (acc0) acc0_cyc = cyc;
    if (acc1) acc1_cyc = cyc;
    if (ram_rx_valid) begin
      obs_rx.push_back(ram_rx_data);
      obs_rx_cyc.push_back(cyc);
      if (ram_auto && ram_rx_data[9:8] == 2'b11) ram_pend = 1'b1;
    end
    if (p0_rvalid) obs_rd.push_back({1'b0, p0_rdata});
    if (p1_rvalid) obs_rd.push_back({1'b1, p1_rdata});
    if (lock_timeout) begin n_lto++; lto_cyc = cyc; end
    if (rd_timeout) begin n_rto++; rto_cyc = cyc; end
    if (stray_rd) n_stray++;
    @(posedge clk);
    if (p0_q.size() > 0 && (p0_q[0][10] || acc0)) void'(p0_q.pop_front());
    if (p1_q.size() > 0 && (p1_q[0][10] || acc1)) void'(p1_q.pop_front());
  endtask

  task automatic run(input int budget, input string name);
    int n = 0;
    while ((p0_q.size() > 0 || p1_q.size() > 0) && n < budget) begin step(); n++; end
    checks++;
    if (p0_q.size() > 0 || p1_q.size() > 0) begin
      errors++;
      $display("FAIL %s_drain: pending %0d required 0", name, p0_q.size() + p1_q.size());
    end
    repeat (4) step();
  endtask

  task automatic do_reset();
    p0_q.delete(); p1_q.delete();
    p0_valid = 1'b0; p1_valid = 1'b0; ram_tx_valid = 1'b0;
    ram_pend = 1'b0; ram_auto = 1'b0; ram_byte = 8'h00;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({ram_rx_valid, ram_rx_data} !== 11'd0) begin errors++;
      $display("FAIL reset_ram_rx: got %h required 000", {ram_rx_valid, ram_rx_data}); end
    checks++; if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata} !== 18'd0) begin errors++;
      $display("FAIL reset_rdata: got %h required 0", {p0_rvalid, p1_rvalid, p0_rdata, p1_rdata}); end
    checks++; if (owner !== 1'b1) begin errors++;
      $display("FAIL reset_owner: got %b required 1", owner); end
    checks++; if ({lock_timeout, rd_timeout, stray_rd, p0_ready, p1_ready} !== 5'd0) begin errors++;
      $display("FAIL reset_flags: got %b required 00000", {lock_timeout, rd_timeout, stray_rd, p0_ready, p1_ready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_pair();
    do_reset();
    p0_q = '{11'h005, 11'h1A5};
    exp_rx = '{10'h005, 10'h1A5};
    run(20, "write_pair");
    checks++; if (obs_rx_cyc.size() < 2 || obs_rx_cyc[1] - obs_rx_cyc[0] != 1) begin errors++;
      $display("FAIL write_pair_spacing: got %0d entries required 2 on consecutive cycles", obs_rx_cyc.size()); end
    p1_q = '{11'h111};
    exp_rx.push_back(10'h111);
    run(3, "write_pair_idle");
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      e10 = exp_rx.pop_front(); o10 = obs_rx.pop_front(); checks++;
      if (o10 !== e10) begin errors++; $display("FAIL write_pair_rx: got %h required %h", o10, e10); end
    end
    checks++; if (exp_rx.size() != 0 || obs_rx.size() != 0) begin errors++;
      $display("FAIL write_pair_count: leftover got %0d required %0d", obs_rx.size(), exp_rx.size()); end
  endtask

  task automatic test_contention();
    bit locked = 1'b0, bad = 1'b0;
    int waited = 0, n = 0;
    do_reset();
    p0_q = '{11'h005, GAP, GAP, GAP, 11'h1A5};
    p1_q = '{GAP, 11'h010, 11'h1CC};
    exp_rx = '{10'h005, 10'h1A5, 10'h010, 10'h1CC};
    while ((p0_q.size() > 0 || p1_q.size() > 0) && n < 40) begin
      step(); n++;
      if (locked && p1_valid) waited++;
      if (locked && acc1) bad = 1'b1;
      if (acc0 && p0_cmd == 10'h005) locked = 1'b1;
      if (acc0 && p0_cmd == 10'h1A5) locked = 1'b0;
    end
    repeat (4) step();
    checks++; if (bad || waited < 3) begin errors++;
      $display("FAIL contention_p1_ready: got grant=%b waited=%0d required grant=0 waited>=3", bad, waited); end
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      e10 = exp_rx.pop_front(); o10 = obs_rx.pop_front(); checks++;
      if (o10 !== e10) begin errors++; $display("FAIL contention_rx: got %h required %h", o10, e10); end
    end
    checks++; if (exp_rx.size() != 0 || obs_rx.size() != 0) begin errors++;
      $display("FAIL contention_count: leftover got %0d required %0d", obs_rx.size(), exp_rx.size()); end
  endtask

  task automatic test_read();
    do_reset();
    ram_auto = 1'b1; ram_byte = 8'hA5;
    p1_q = '{11'h205, 11'h300};
    exp_rx = '{10'h205, 10'h300};
    exp_rd = '{9'h1A5};
    run(20, "read_p1");
    ram_byte = 8'h5A;
    p0_q = '{11'h300};
    exp_rx.push_back(10'h300);
    exp_rd.push_back(9'h05A);
    run(20, "read_p0");
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      e10 = exp_rx.pop_front(); o10 = obs_rx.pop_front(); checks++;
      if (o10 !== e10) begin errors++; $display("FAIL read_rx: got %h required %h", o10, e10); end
    end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      e9 = exp_rd.pop_front(); o9 = obs_rd.pop_front(); checks++;
      if (o9 !== e9) begin errors++; $display("FAIL read_rdata: got port/data %h required %h", o9, e9); end
    end
    checks++; if (exp_rd.size() != 0 || obs_rd.size() != 0 || exp_rx.size() != 0 || obs_rx.size() != 0) begin errors++;
      $display("FAIL read_count: leftover rd %0d/%0d rx %0d/%0d required 0", obs_rd.size(), exp_rd.size(), obs_rx.size(), exp_rx.size()); end
    checks++; if (p1_rdata !== 8'hA5 || p0_rdata !== 8'h5A) begin errors++;
      $display("FAIL read_hold: got p0=%h p1=%h required p0=5a p1=a5", p0_rdata, p1_rdata); end
    ram_auto = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    p0_q = '{11'h1A0, 11'h1A1};
    p1_q = '{11'h1B0, 11'h1B1};
    exp_rx = '{10'h1A0, 10'h1B0, 10'h1A1, 10'h1B1};
    run(20, "round_robin");
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      e10 = exp_rx.pop_front(); o10 = obs_rx.pop_front(); checks++;
      if (o10 !== e10) begin errors++; $display("FAIL round_robin_rx: got %h required %h", o10, e10); end
    end
    checks++; if (exp_rx.size() != 0 || obs_rx.size() != 0 || owner !== 1'b1) begin errors++;
      $display("FAIL round_robin_end: leftover %0d/%0d owner %b required 0/0 owner 1", obs_rx.size(), exp_rx.size(), owner); end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    p0_q = '{11'h005};
    p1_q = '{GAP, 11'h1EE};
    exp_rx = '{10'h005, 10'h1EE};
    run(LOCK_TIMEOUT + 20, "lock_timeout");
    checks++; if (n_lto != 1) begin errors++;
      $display("FAIL lock_timeout_pulses: got %0d required 1", n_lto); end
    checks++; if (acc1_cyc - acc0_cyc != LOCK_TIMEOUT + 1 || lto_cyc != acc1_cyc) begin errors++;
      $display("FAIL lock_timeout_timing: got grant gap %0d pulse at %0d required gap %0d pulse at %0d",
               acc1_cyc - acc0_cyc, lto_cyc, LOCK_TIMEOUT + 1, acc1_cyc); end
    while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
      e10 = exp_rx.pop_front(); o10 = obs_rx.pop_front(); checks++;
      if (o10 !== e10) begin errors++; $display("FAIL lock_timeout_rx: got %h required %h", o10, e10); end
    end
  endtask

  task automatic test_rd_timeout();
    do_reset();
    p0_q = '{11'h300};
    exp_rx = '{10'h300};
    run(10, "rd_timeout");
    repeat (RD_TIMEOUT + 4) step();
    checks++; if (n_rto != 1 || rto_cyc - acc0_cyc != RD_TIMEOUT + 1) begin errors++;
      $display("FAIL rd_timeout_pulse: got %0d pulses delay %0d required 1 pulse delay %0d", n_rto, rto_cyc - acc0_cyc, RD_TIMEOUT + 1); end
    checks++; if (obs_rd.size() != 0 || n_stray != 0) begin errors++;
      $display("FAIL rd_timeout_quiet: got rvalid %0d stray %0d required 0 0", obs_rd.size(), n_stray); end
    ram_byte = 8'h77; ram_pend = 1'b1;
    repeat (3) step();
    checks++; if (n_stray != 1 || obs_rd.size() != 0 || p0_rdata !== 8'h00) begin errors++;
      $display("FAIL stray_rd: got stray %0d rvalid %0d rdata %h required 1 0 00", n_stray, obs_rd.size(), p0_rdata); end
    e10 = exp_rx.pop_front(); o10 = obs_rx.pop_front(); checks++;
    if (o10 !== e10) begin errors++; $display("FAIL rd_timeout_rx: got %h required %h", o10, e10); end
  endtask

  task automatic test_reset_midread();
    do_reset();
    p0_q = '{11'h300};
    run(10, "midread");
    @(negedge clk); #2 rst_n = 1'b0; #1;
    checks++; if (owner !== 1'b1 || ram_rx_valid !== 1'b0) begin errors++;
      $display("FAIL midread_async: got owner %b rx_valid %b required 1 0", owner, ram_rx_valid); end
    @(negedge clk); rst_n = 1'b1;
    clear_obs();
    ram_byte = 8'h3C; ram_pend = 1'b1;
    repeat (RD_TIMEOUT + 4) step();
    checks++; if (obs_rd.size() != 0 || n_stray != 1 || n_rto != 0) begin errors++;
      $display("FAIL midread_lost: got rvalid %0d stray %0d rto %0d required 0 1 0", obs_rd.size(), n_stray, n_rto); end
  endtask

  initial begin
    ram_byte = 8'h00; ram_pend = 1'b0; ram_auto = 1'b0;
    clear_obs();
    test_reset();
    test_round_robin();
    test_write_pair();
    test_contention();
    test_read();
    test_lock_timeout();
    test_rd_timeout();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
